// File: rtl/branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Purpose
//   Hazard controller for a branch resolved in the ID stage. The branch
//   operands (id_rs / id_rt) are checked against the destinations of the
//   instructions currently in EX and MEM:
//     - a load in EX needs two stall cycles before its data can be forwarded;
//     - an ALU op in EX, or a load in MEM, needs one stall cycle;
//     - an ALU op in MEM is forwarded straight into the comparator.
//   While stalled, the comparator is suppressed, PC and IF/ID are frozen and
//   a bubble is pushed into ID/EX. When not stalled, a taken comparator
//   result redirects the PC and flushes IF/ID in the same cycle.
//
//   The stall length is held in a small down-counter. Once a stall has
//   started, the hazard inputs are ignored until the counter expires. On
//   the first IDLE cycle afterwards the hazard check runs again, so a new
//   hazard starts a new stall.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous reset, active low
//   branch_cond    ID branch type (BR_NOT_BRANCH disables all operand matching)
//   id_rs, id_rt   branch source registers
//   ex_reg_write   EX instruction writes the register file
//   ex_mem_read    EX instruction is a load
//   ex_rd          EX destination register
//   mem_reg_write  MEM instruction writes the register file
//   mem_mem_read   MEM instruction is a load
//   mem_rd         MEM destination register
//   branch_check   comparator result (taken)
//   stall_compare  suppress comparator, freeze PC and IF/ID
//   idex_bubble    insert NOP into ID/EX
//   fwd_a, fwd_b   1 = compare operand from EX/MEM ALU result, 0 = regfile
//   pc_src         load branch target into PC
//   ifid_flush     clear IF/ID on the next edge
//   stall_cycles   (BRANCH_STALL_STATS_EN only) saturating count of stall cycles
//   taken_count    (BRANCH_STALL_STATS_EN only) saturating count of redirects
//
// Configuration
//   Define BRANCH_STALL_STATS_EN to add the two 32-bit statistics counters.
//   The hazard behaviour is identical with or without them.
// -----------------------------------------------------------------------------
module branch_hazard_ctrl #(
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         branch_cond,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               ex_reg_write,
  input  logic               ex_mem_read,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               mem_reg_write,
  input  logic               mem_mem_read,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic               branch_check,
  output logic               stall_compare,
  output logic               idex_bubble,
  output logic               fwd_a,
  output logic               fwd_b,
  output logic               pc_src,
`ifdef BRANCH_STALL_STATS_EN
  output logic [31:0]        stall_cycles,
  output logic [31:0]        taken_count,
`endif
  output logic               ifid_flush
);

  // Branch-type encoding shared with the decoder. Only "not a branch" affects
  // this block; beq (2'b01) and bne (2'b10) are treated the same way.
  localparam logic [1:0] BR_NOT_BRANCH = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic               br_active;
  logic [CNT_W-1:0]   need_rs;
  logic [CNT_W-1:0]   need_rt;
  logic [CNT_W-1:0]   need_n;
  logic               stall;

  // A source register matches a producer only for a real branch, and r0 never
  // matches because it is hard-wired to zero.
  function automatic logic reg_hit(input logic               active,
                                   input logic [RADDR_W-1:0] src,
                                   input logic [RADDR_W-1:0] dst);
    return active && (dst != '0) && (dst == src);
  endfunction

  // Stall cycles needed before one source operand can be read or forwarded.
  function automatic logic [CNT_W-1:0] stall_need(input logic active,
                                                  input logic [RADDR_W-1:0] src);
    logic hit_ex;
    logic hit_mem;
    hit_ex  = reg_hit(active, src, ex_rd);
    hit_mem = reg_hit(active, src, mem_rd);
    if (ex_mem_read && hit_ex) begin
      return CNT_W'(2);
    end else if (ex_reg_write && hit_ex) begin
      return CNT_W'(1);
    end else if (mem_mem_read && hit_mem) begin
      return CNT_W'(1);
    end
    return '0;
  endfunction

  assign br_active = (branch_cond != BR_NOT_BRANCH);

  always_comb begin
    need_rs = stall_need(br_active, id_rs);
    need_rt = stall_need(br_active, id_rt);
    need_n  = (need_rs > need_rt) ? need_rs : need_rt;
  end

  // ---- state register ------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---- next state / stall decision -----------------------------------------
  // The current cycle is always one of the stall cycles. The counter keeps
  // the number of stall cycles that remain after it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (need_n != '0) begin
          stall   = 1'b1;
          cnt_nxt = need_n - CNT_W'(1);
          if (need_n > CNT_W'(1)) begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // WAIT is entered only with cnt >= 1, so this decrement cannot wrap.
        stall   = 1'b1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---- outputs -------------------------------------------------------------
  assign stall_compare = stall;
  assign idex_bubble   = stall;

  // Only a non-load ALU result in MEM can be forwarded. Load data is not
  // available yet at that point. WB needs no forwarding because the
  // register file is written before it is read.
  assign fwd_a = mem_reg_write && !mem_mem_read && reg_hit(br_active, id_rs, mem_rd);
  assign fwd_b = mem_reg_write && !mem_mem_read && reg_hit(br_active, id_rt, mem_rd);

  // A taken result during a stall means the comparator fault; it is ignored.
  assign pc_src     = branch_check && !stall;
  assign ifid_flush = branch_check && !stall;

`ifdef BRANCH_STALL_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- statistics counters -------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      taken_count  <= '0;
    end else begin
      if (stall) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      if (branch_check && !stall) begin
        taken_count <= sat_inc(taken_count);
      end
    end
  end
`endif

endmodule
